// File: rtl/btn_gesture_ctrl_pkg.sv
// Shared state encodings and default millisecond constants for the button gesture path.
// Also used by the btn_deb_onepulse_ce benches.
package btn_gesture_ctrl_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DOWN1 = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_DOWN2 = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam int DEF_LONG_MS    = 800;
    localparam int DEF_DBL_GAP_MS = 300;
    localparam int DEF_REPEAT_MS  = 100;
    localparam int DEF_CNT_W      = 10;

    // States in which the button is expected to be physically down
    function automatic logic is_held_state(input logic [2:0] s);
        return (s == S_DOWN1) || (s == S_DOWN2) || (s == S_HOLD);
    endfunction

endpackage

// File: rtl/btn_gesture_ctrl_ms_tick_timer.sv
// Millisecond timer for the gesture FSM: clear, tick increment, saturation.
// o_hit flags the tick on which the count becomes i_cmp.
module ms_tick_timer #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_cmp,
    output logic             o_hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cmp_m1;

    assign w_cmp_m1 = i_cmp - 1'b1;

    // Independent of i_clr: the clear decision is itself derived from o_hit
    assign o_hit = i_inc && (r_cnt == w_cmp_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/btn_gesture_ctrl.sv
// Button gesture sequencer: single click, double click, long press.
// Define AUTO_REPEAT_EN to emit repeat pulses while a long press is held.
module btn_gesture_ctrl
    import btn_gesture_ctrl_pkg::*;
#(
    parameter int LONG_MS    = DEF_LONG_MS,
    parameter int DBL_GAP_MS = DEF_DBL_GAP_MS,
    parameter int REPEAT_MS  = DEF_REPEAT_MS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_ce,
    input  logic pressed,
    input  logic press_pulse,
    input  logic release_pulse,
    output logic click,
    output logic dbl_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic busy
);

    generate
        if (LONG_MS < 2 || DBL_GAP_MS < 2 || REPEAT_MS < 1 ||
            LONG_MS >= 2**CNT_W || DBL_GAP_MS >= 2**CNT_W ||
            REPEAT_MS >= 2**CNT_W) begin : g_bad_param
            $error("btn_gesture_ctrl: *_MS out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_MS);
    localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(DBL_GAP_MS);
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_MS);
`endif

    logic [2:0]       r_state;
    logic             r_click;
    logic             r_dbl;
    logic             r_long;

    logic [2:0]       w_nstate;
    logic             w_click_d;
    logic             w_dbl_d;
    logic             w_long_d;
    logic             w_rep_d;
    logic             w_rclr;
    logic             w_clr;
    logic             w_inc;
    logic             w_hit;
    logic [CNT_W-1:0] w_cmp;

    // A same-cycle press or release consumes the tick
    assign w_inc = tick_ce && !press_pulse && !release_pulse;
    assign w_clr = (w_nstate != r_state) || w_rclr;

    always_comb begin
        w_cmp = LONG_C;
        case (r_state)
            S_GAP:   w_cmp = GAP_C;
`ifdef AUTO_REPEAT_EN
            S_HOLD:  w_cmp = REP_C;
`endif
            default: w_cmp = LONG_C;
        endcase
    end

    ms_tick_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .i_inc (w_inc),
        .i_cmp (w_cmp),
        .o_hit (w_hit)
    );

    always_comb begin
        w_nstate  = r_state;
        w_click_d = 1'b0;
        w_dbl_d   = 1'b0;
        w_long_d  = 1'b0;
        w_rep_d   = 1'b0;
        w_rclr    = 1'b0;
        // Lost release: level says up but no pulse arrived
        if (is_held_state(r_state) && !release_pulse && !pressed) begin
            w_nstate = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (press_pulse && !release_pulse) begin
                        w_nstate = S_DOWN1;
                    end
                end
                S_DOWN1: begin
                    if (release_pulse) begin
                        w_nstate = S_GAP;
                    end else if (w_hit) begin
                        w_long_d = 1'b1;
                        w_nstate = S_HOLD;
                    end
                end
                S_GAP: begin
                    if (press_pulse && !release_pulse) begin
                        w_nstate = S_DOWN2;
                    end else if (w_hit) begin
                        w_click_d = 1'b1;
                        w_nstate  = S_IDLE;
                    end
                end
                S_DOWN2: begin
                    if (release_pulse) begin
                        w_dbl_d  = 1'b1;
                        w_nstate = S_IDLE;
                    end else if (w_hit) begin
                        w_click_d = 1'b1;
                        w_long_d  = 1'b1;
                        w_nstate  = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (release_pulse) begin
                        w_nstate = S_IDLE;
`ifdef AUTO_REPEAT_EN
                    end else if (w_hit) begin
                        w_rep_d = 1'b1;
                        w_rclr  = 1'b1;
`endif
                    end
                end
                default: begin
                    w_nstate = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_click <= 1'b0;
            r_dbl   <= 1'b0;
            r_long  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_click <= w_click_d;
            r_dbl   <= w_dbl_d;
            r_long  <= w_long_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    logic r_rep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep <= 1'b0;
        end else begin
            r_rep <= w_rep_d;
        end
    end

    assign repeat_pulse = r_rep;
`else
    logic w_rep_unused;

    assign w_rep_unused = w_rep_d | w_rclr;
    assign repeat_pulse = 1'b0;
`endif

    assign click      = r_click;
    assign dbl_click  = r_dbl;
    assign long_press = r_long;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_btn_gesture_ctrl.sv
// Directed bench for btn_gesture_ctrl: per-cycle vector table plus ms-scale gesture sequences.
// Build with +define+AUTO_REPEAT_EN to also cover the repeat path.
module tb_btn_gesture_ctrl;

    localparam int LONG = 20;
    localparam int GAP  = 10;
    localparam int REP  = 5;

    logic clk           = 1'b0;
    logic rst_n         = 1'b0;
    logic tick_ce       = 1'b0;
    logic pressed       = 1'b0;
    logic press_pulse   = 1'b0;
    logic release_pulse = 1'b0;
    logic click, dbl_click, long_press, repeat_pulse, busy;

    int n_chk = 0;
    int n_err = 0;
    int c_click, c_dbl, c_long, c_rep;

    always #5 clk = ~clk;

    btn_gesture_ctrl #(
        .LONG_MS    (LONG),
        .DBL_GAP_MS (GAP),
        .REPEAT_MS  (REP),
        .CNT_W      (10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick_ce       (tick_ce),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .click         (click),
        .dbl_click     (dbl_click),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .busy          (busy)
    );

    always @(negedge clk) begin
        if (click)        c_click = c_click + 1;
        if (dbl_click)    c_dbl   = c_dbl + 1;
        if (long_press)   c_long  = c_long + 1;
        if (repeat_pulse) c_rep   = c_rep + 1;
    end

    typedef struct {
        int         n;
        logic       tk;
        logic       pr;
        logic       pp;
        logic       rp;
        logic [4:0] exp;   // {busy, click, dbl, long, rep}
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_ms(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (99) cyc();
            tick_ce = 1'b1;
            cyc();
            tick_ce = 1'b0;
        end
    endtask

    task automatic do_press();
        pressed     = 1'b1;
        press_pulse = 1'b1;
        cyc();
        press_pulse = 1'b0;
    endtask

    task automatic do_release();
        pressed       = 1'b0;
        release_pulse = 1'b1;
        cyc();
        release_pulse = 1'b0;
    endtask

    task automatic zero_counts();
        c_click = 0;
        c_dbl   = 0;
        c_long  = 0;
        c_rep   = 0;
    endtask

    function automatic logic [4:0] outs();
        return {busy, click, dbl_click, long_press, repeat_pulse};
    endfunction

    int exp_rep;

    initial begin
        zero_counts();
        // press coincident with tick: timer must start from 0
        tbl.push_back('{1,  1'b1, 1'b1, 1'b1, 1'b0, 5'b10000});
        tbl.push_back('{19, 1'b1, 1'b1, 1'b0, 1'b0, 5'b10000});
        tbl.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b0, 5'b10010});
        tbl.push_back('{1,  1'b0, 1'b0, 1'b0, 1'b0, 5'b00000});
        // stray release in idle
        tbl.push_back('{1,  1'b0, 1'b0, 1'b0, 1'b1, 5'b00000});
        // desync in DOWN1
        tbl.push_back('{1,  1'b0, 1'b1, 1'b1, 1'b0, 5'b10000});
        tbl.push_back('{3,  1'b1, 1'b1, 1'b0, 1'b0, 5'b10000});
        tbl.push_back('{1,  1'b0, 1'b0, 1'b0, 1'b0, 5'b00000});
        tbl.push_back('{25, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000});
        // release beats press and tick; gap then times out
        tbl.push_back('{1,  1'b0, 1'b1, 1'b1, 1'b0, 5'b10000});
        tbl.push_back('{1,  1'b1, 1'b0, 1'b1, 1'b1, 5'b10000});
        tbl.push_back('{9,  1'b1, 1'b0, 1'b0, 1'b0, 5'b10000});
        tbl.push_back('{1,  1'b1, 1'b0, 1'b0, 1'b0, 5'b01000});

        // reset state
        rst_n = 1'b0;
        repeat (3) cyc();
        chk("reset_outs", outs(), 5'b00000);
        rst_n = 1'b1;
        cyc();

        // 1: single click
        zero_counts();
        do_press();
        tick_ms(5);
        do_release();
        tick_ms(GAP - 1);
        chk("t1_no_early_click", c_click, 0);
        tick_ms(1);
        chk("t1_click_at_gap", click, 1);
        tick_ms(5);
        chk("t1_click_count", c_click, 1);
        chk("t1_dbl_count", c_dbl, 0);
        chk("t1_long_count", c_long, 0);
        chk("t1_busy", busy, 0);

        // 2: double click
        zero_counts();
        do_press();
        tick_ms(5);
        do_release();
        tick_ms(4);
        do_press();
        tick_ms(5);
        do_release();
        chk("t2_dbl_on_release", dbl_click, 1);
        tick_ms(12);
        chk("t2_dbl_count", c_dbl, 1);
        chk("t2_click_count", c_click, 0);
        chk("t2_long_count", c_long, 0);
        chk("t2_busy", busy, 0);

        // 3: long press and hold
        zero_counts();
        do_press();
        tick_ms(LONG - 1);
        chk("t3_no_early_long", c_long, 0);
        tick_ms(1);
        chk("t3_long_at_20", long_press, 1);
        chk("t3_busy_hold", busy, 1);
`ifdef AUTO_REPEAT_EN
        tick_ms(REP - 1);
        chk("t3_no_early_rep", c_rep, 0);
        tick_ms(1);
        chk("t3_rep_at_25", repeat_pulse, 1);
        tick_ms(REP);
        chk("t3_rep_at_30", repeat_pulse, 1);
        exp_rep = 2;
`else
        tick_ms(10);
        exp_rep = 0;
`endif
        do_release();
        chk("t3_busy_after_rel", busy, 0);
        tick_ms(10);
        chk("t3_rep_count", c_rep, exp_rep);
        chk("t3_long_count", c_long, 1);
        chk("t3_click_count", c_click, 0);

        // 4: click then long press on second press
        zero_counts();
        do_press();
        tick_ms(5);
        do_release();
        tick_ms(4);
        do_press();
        tick_ms(LONG - 1);
        chk("t4_no_early", c_click + c_long, 0);
        tick_ms(1);
        chk("t4_click_long_same", {click, long_press}, 2'b11);
        do_release();
        tick_ms(12);
        chk("t4_click_count", c_click, 1);
        chk("t4_long_count", c_long, 1);
        chk("t4_dbl_count", c_dbl, 0);
        chk("t4_busy", busy, 0);

        // 5: async reset mid-gap
        zero_counts();
        do_press();
        tick_ms(5);
        do_release();
        tick_ms(3);
        chk("t5_busy_in_gap", busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_async_outs", outs(), 5'b00000);
        cyc();
        rst_n = 1'b1;
        tick_ms(15);
        chk("t5_no_click", c_click, 0);
        chk("t5_busy", busy, 0);

        // 6: per-cycle vector table
        for (int v = 0; v < tbl.size(); v++) begin
            for (int k = 0; k < tbl[v].n; k++) begin
                tick_ce       = tbl[v].tk;
                pressed       = tbl[v].pr;
                press_pulse   = tbl[v].pp;
                release_pulse = tbl[v].rp;
                cyc();
                chk($sformatf("vec%0d_c%0d", v, k), outs(), tbl[v].exp);
            end
        end
        tick_ce       = 1'b0;
        press_pulse   = 1'b0;
        release_pulse = 1'b0;
        pressed       = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
